blob_stats_acc: RTL and testbench

Parametrised successor to the single-configuration pixel accumulator. Scans a binary mask frame stored one row per word in a block RAM, processing `LANES` pixels per cycle. For every set pixel it accumulates the pixel count, Σx and Σy at full precision. It sits between the mask BRAM port B and the centroid/tracking logic, and adds an explicit start/busy/done handshake, abort, and an optional bounding box.

---
 rtl/blob_stats_pkg.sv | 45 ++++
 rtl/blob_stats_acc_if.sv | 50 +++++
 rtl/blob_stats_acc_lane_reduce.sv | 85 ++++++++
 rtl/blob_stats_acc.sv | 194 +++++++++++++++++++
 tb/tb_blob_stats_acc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/blob_stats_pkg.sv
// blob_stats_pkg: state encoding, width helpers and configuration check shared by blob_stats_acc.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package blob_stats_pkg;

  // Scan FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SCAN  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Lane-index sums are carried at a fixed width that covers the widest supported chunk
  localparam int MAX_LANES      = 64;
  localparam int LANE_IDX_SUM_W = $clog2(MAX_LANES * (MAX_LANES - 1) / 2 + 1);

  function automatic int x_w_f(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int y_w_f(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

  function automatic int cnt_w_f(input int img_w, input int img_h);
    return $clog2(img_w * img_h + 1);
  endfunction

  function automatic int lane_w_f(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int lane_cnt_w_f(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Elaboration-time legality: whole chunks per row and every row addressable
  function automatic bit cfg_ok(input int img_w, input int img_h, input int lanes,
                                input int row_base, input int addr_w);
    return (lanes >= 1) && (lanes <= MAX_LANES) && (img_w % lanes == 0) &&
           (img_h >= 1) && (img_h <= (1 << addr_w) - row_base);
  endfunction

endpackage

// File: rtl/blob_stats_acc_if.sv
// blob_stats_acc_if: control handshake, mask BRAM port B and result bus of blob_stats_acc.
// Latency: n/a (wires only); slave = accumulator, master = controller/BRAM side.
// Backpressure: none; start/abort/done handshake, bbox signals exist only with BLOB_STATS_BBOX_EN.
interface blob_stats_acc_if #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 9
);
  localparam int X_W   = blob_stats_pkg::x_w_f(IMG_W);
  localparam int Y_W   = blob_stats_pkg::y_w_f(IMG_H);
  localparam int CNT_W = blob_stats_pkg::cnt_w_f(IMG_W, IMG_H);

  logic                   start;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic                   mem_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [IMG_W-1:0]       mem_rdata;
  logic [CNT_W-1:0]       count;
  logic [CNT_W+X_W-1:0]   sum_x;
  logic [CNT_W+Y_W-1:0]   sum_y;
`ifdef BLOB_STATS_BBOX_EN
  logic [X_W-1:0]         min_x;
  logic [X_W-1:0]         max_x;
  logic [Y_W-1:0]         min_y;
  logic [Y_W-1:0]         max_y;

  modport slave (
    input  start, abort, mem_rdata,
    output busy, done, mem_en, mem_addr, count, sum_x, sum_y,
           min_x, max_x, min_y, max_y
  );
  modport master (
    output start, abort, mem_rdata,
    input  busy, done, mem_en, mem_addr, count, sum_x, sum_y,
           min_x, max_x, min_y, max_y
  );
`else
  modport slave (
    input  start, abort, mem_rdata,
    output busy, done, mem_en, mem_addr, count, sum_x, sum_y
  );
  modport master (
    output start, abort, mem_rdata,
    input  busy, done, mem_en, mem_addr, count, sum_x, sum_y
  );
`endif

endinterface

// File: rtl/blob_stats_acc_lane_reduce.sv
// lane_reduce: popcount, set-lane index sum and (BLOB_STATS_BBOX_EN) first/last set lane of one chunk.
// Latency: 1 cycle (combinational reduction into one output register stage).
// Backpressure: none; clr drops any held result and wins over in_vld.
// Ports: clk/rst_n, clr, in_vld + chunk in; out_vld, cnt, isum (+ first_idx/last_idx) out.
module lane_reduce #(
  parameter int LANES = 32
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             clr,
  input  logic                                             in_vld,
  input  logic [LANES-1:0]                                 chunk,
  output logic                                             out_vld,
  output logic [blob_stats_pkg::lane_cnt_w_f(LANES)-1:0]   cnt,
  output logic [blob_stats_pkg::LANE_IDX_SUM_W-1:0]        isum
`ifdef BLOB_STATS_BBOX_EN
  ,
  output logic [blob_stats_pkg::lane_w_f(LANES)-1:0]       first_idx,
  output logic [blob_stats_pkg::lane_w_f(LANES)-1:0]       last_idx
`endif
);
  import blob_stats_pkg::*;

  localparam int CW = lane_cnt_w_f(LANES);
  localparam int LW = lane_w_f(LANES);

  logic [CW-1:0]             cnt_c;
  logic [LANE_IDX_SUM_W-1:0] isum_c;

  // Lane i is chunk bit LANES-1-i, so lane 0 is the leftmost pixel of the chunk
  always_comb begin
    cnt_c  = '0;
    isum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (chunk[LANES-1-i]) begin
        cnt_c  = cnt_c + CW'(1);
        isum_c = isum_c + LANE_IDX_SUM_W'(i);
      end
    end
  end

`ifdef BLOB_STATS_BBOX_EN
  logic [LW-1:0] first_c;
  logic [LW-1:0] last_c;
  logic          found_c;

  always_comb begin
    first_c = '0;
    last_c  = '0;
    found_c = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (chunk[LANES-1-i]) begin
        if (!found_c) first_c = LW'(i);
        found_c = 1'b1;
        last_c  = LW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_idx <= '0;
      last_idx  <= '0;
    end else if (in_vld && !clr) begin
      first_idx <= first_c;
      last_idx  <= last_c;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      cnt     <= '0;
      isum    <= '0;
    end else begin
      out_vld <= in_vld && !clr;
      if (in_vld && !clr) begin
        cnt  <= cnt_c;
        isum <= isum_c;
      end
    end
  end

endmodule

// File: rtl/blob_stats_acc.sv
// blob_stats_acc: scans a binary mask frame (one row per BRAM word, LANES px/cycle) accumulating count, sum x, sum y.
// Latency: done at cycle 1 + IMG_H*(IMG_W/LANES+2) + 2 after start; BRAM read latency of one cycle assumed.
// Backpressure: none; start ignored while busy, abort returns to idle with cleared results. Bbox needs BLOB_STATS_BBOX_EN.
// Ports: clk, rst_n (async active-low), bus (blob_stats_acc_if.slave: start/abort/busy/done, mem_*, results).
module blob_stats_acc #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int LANES    = 32,
  parameter int ROW_BASE = 1,
  parameter int ADDR_W   = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  blob_stats_acc_if.slave bus
);
  import blob_stats_pkg::*;

  localparam int X_W   = x_w_f(IMG_W);
  localparam int Y_W   = y_w_f(IMG_H);
  localparam int CNT_W = cnt_w_f(IMG_W, IMG_H);
  localparam int SX_W  = CNT_W + X_W;
  localparam int SY_W  = CNT_W + Y_W;
  localparam int CW    = lane_cnt_w_f(LANES);
  localparam int LW    = lane_w_f(LANES);

  if (!cfg_ok(IMG_W, IMG_H, LANES, ROW_BASE, ADDR_W)) begin : g_cfg_err
    $error("blob_stats_acc: IMG_W must be a multiple of LANES and all rows must be addressable");
  end

  logic [2:0]       state_q, state_d;
  logic [Y_W-1:0]   y_q;
  logic [X_W-1:0]   base_x_q;
  logic [IMG_W-1:0] row_q;
  logic             flush_q;

  logic start_acc, abort_acc, clr, last_chunk, last_row, scan_vld;

  assign start_acc  = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign abort_acc  = (state_q != ST_IDLE) && bus.abort;
  assign clr        = start_acc || abort_acc;
  assign last_chunk = (base_x_q == X_W'(IMG_W - LANES));
  assign last_row   = (y_q == Y_W'(IMG_H - 1));
  assign scan_vld   = (state_q == ST_SCAN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_SCAN;
      ST_SCAN:  if (last_chunk) state_d = last_row ? ST_FLUSH : ST_FETCH;
      ST_FLUSH: if (flush_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_acc) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      y_q      <= '0;
      base_x_q <= '0;
      row_q    <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Second FLUSH cycle is marked so the reducer and accumulator have both drained
      flush_q <= (state_q == ST_FLUSH) && !flush_q && !abort_acc;
      if (clr) begin
        y_q <= '0;
      end else if (scan_vld && last_chunk && !last_row) begin
        y_q <= y_q + Y_W'(1);
      end
      if (state_q == ST_WAIT) begin
        row_q    <= bus.mem_rdata;
        base_x_q <= '0;
      end else if (scan_vld) begin
        row_q    <= row_q << LANES;
        base_x_q <= base_x_q + X_W'(LANES);
      end
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.mem_en   = (state_q == ST_FETCH);
  assign bus.mem_addr = ADDR_W'(ROW_BASE) + ADDR_W'(y_q);

  // Reducer stage: chunk coordinates travel alongside so y may advance before the sum lands
  logic                      red_vld;
  logic [CW-1:0]             red_cnt;
  logic [LANE_IDX_SUM_W-1:0] red_isum;
  logic [X_W-1:0]            s1_bx;
  logic [Y_W-1:0]            s1_y;
`ifdef BLOB_STATS_BBOX_EN
  logic [LW-1:0]             red_first;
  logic [LW-1:0]             red_last;
`endif

  lane_reduce #(.LANES(LANES)) u_lane_reduce (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_vld    (scan_vld),
    .chunk     (row_q[IMG_W-1 -: LANES]),
    .out_vld   (red_vld),
    .cnt       (red_cnt),
    .isum      (red_isum)
`ifdef BLOB_STATS_BBOX_EN
    ,
    .first_idx (red_first),
    .last_idx  (red_last)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_bx <= '0;
      s1_y  <= '0;
    end else if (scan_vld) begin
      s1_bx <= base_x_q;
      s1_y  <= y_q;
    end
  end

  logic [CNT_W-1:0] count_q;
  logic [SX_W-1:0]  sum_x_q;
  logic [SY_W-1:0]  sum_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
    end else if (clr) begin
      count_q <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
    end else if (red_vld) begin
      count_q <= count_q + CNT_W'(red_cnt);
      sum_x_q <= sum_x_q + SX_W'(red_cnt) * SX_W'(s1_bx) + SX_W'(red_isum);
      sum_y_q <= sum_y_q + SY_W'(red_cnt) * SY_W'(s1_y);
    end
  end

  assign bus.count = count_q;
  assign bus.sum_x = sum_x_q;
  assign bus.sum_y = sum_y_q;

`ifdef BLOB_STATS_BBOX_EN
  logic [X_W-1:0] x_lo, x_hi;
  logic [X_W-1:0] min_x_q, max_x_q;
  logic [Y_W-1:0] min_y_q, max_y_q;
  logic           seen_q;

  assign x_lo = s1_bx + X_W'(red_first);
  assign x_hi = s1_bx + X_W'(red_last);

  // Rows arrive in increasing y, so min_y is fixed by the first set pixel and max_y tracks the latest row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      seen_q  <= 1'b0;
    end else if (clr) begin
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      seen_q  <= 1'b0;
    end else if (red_vld && (red_cnt != '0)) begin
      seen_q  <= 1'b1;
      max_y_q <= s1_y;
      if (!seen_q) begin
        min_x_q <= x_lo;
        max_x_q <= x_hi;
        min_y_q <= s1_y;
      end else begin
        if (x_lo < min_x_q) min_x_q <= x_lo;
        if (x_hi > max_x_q) max_x_q <= x_hi;
      end
    end
  end

  assign bus.min_x = min_x_q;
  assign bus.max_x = max_x_q;
  assign bus.min_y = min_y_q;
  assign bus.max_y = max_y_q;
`endif

endmodule

// File: tb/tb_blob_stats_acc.sv
// tb_blob_stats_acc: directed frames against a one-cycle-latency BRAM model, results checked by a done-triggered scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_blob_stats_acc;
  import blob_stats_pkg::*;

  localparam int IMG_W    = 640;
  localparam int IMG_H    = 480;
  localparam int LANES    = 32;
  localparam int ROW_BASE = 1;
  localparam int ADDR_W   = 9;
  localparam int DONE_CYC = 1 + IMG_H * (IMG_W / LANES + 2) + 2;

  typedef struct {
    string  name;
    longint cnt, sx, sy;
    int     mnx, mxx, mny, mxy;
    int     start_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  blob_stats_acc_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) bus ();

  blob_stats_acc #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .LANES(LANES), .ROW_BASE(ROW_BASE), .ADDR_W(ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  int   mode   = 0;
  int   en_cnt = 0;
  int   last_addr = 0;
  exp_t sb[$];

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Mask patterns: 0 empty, 1 full, 2 pixels (5,7)+(600,300), 3 pixel (639,479); bit IMG_W-1 is x=0
  function automatic logic [IMG_W-1:0] row_word(input int y);
    logic [IMG_W-1:0] w;
    w = '0;
    case (mode)
      1: w = '1;
      2: begin
        if (y == 7)   w[IMG_W-1-5]   = 1'b1;
        if (y == 300) w[IMG_W-1-600] = 1'b1;
      end
      3: if (y == 479) w[0] = 1'b1;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Synchronous-read BRAM: data appears the cycle after mem_en
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= row_word(int'(bus.mem_addr) - ROW_BASE);
      en_cnt        <= en_cnt + 1;
      last_addr     <= int'(bus.mem_addr);
    end
  end

  // Monitor: every done pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at edge %0d expected none", edges);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_done_cycle"}, longint'(edges - e.start_edge + 1), longint'(DONE_CYC));
        chk({e.name, "_count"}, longint'(bus.count), e.cnt);
        chk({e.name, "_sum_x"}, longint'(bus.sum_x), e.sx);
        chk({e.name, "_sum_y"}, longint'(bus.sum_y), e.sy);
`ifdef BLOB_STATS_BBOX_EN
        chk({e.name, "_min_x"}, longint'(bus.min_x), longint'(e.mnx));
        chk({e.name, "_max_x"}, longint'(bus.max_x), longint'(e.mxx));
        chk({e.name, "_min_y"}, longint'(bus.min_y), longint'(e.mny));
        chk({e.name, "_max_y"}, longint'(bus.max_y), longint'(e.mxy));
`endif
      end
    end
  end

  // Issue start; returns at the negedge of cycle 1 with the sampling edge number
  task automatic run_frame(input int m, input string nm, input longint c, input longint sx,
                           input longint sy, input int mnx, input int mxx, input int mny,
                           input int mxy, input bit push, output int e0);
    exp_t e;
    @(negedge clk);
    mode      = m;
    en_cnt    = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e0 = edges;
    chk({nm, "_busy_after_start"}, longint'(bus.busy), 1);
    if (push) begin
      e.name = nm; e.cnt = c; e.sx = sx; e.sy = sy;
      e.mnx = mnx; e.mxx = mxx; e.mny = mny; e.mxy = mxy;
      e.start_edge = e0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < DONE_CYC + 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", nm, DONE_CYC + 200);
      sb.delete();
    end
    @(negedge clk);
    chk({nm, "_busy_after_done"}, longint'(bus.busy), 0);
  endtask

  task automatic wait_cycle(input int e0, input int cyc);
    while (edges < e0 + cyc - 1) @(negedge clk);
  endtask

  int e0;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    chk("rst_busy",     longint'(bus.busy), 0);
    chk("rst_done",     longint'(bus.done), 0);
    chk("rst_mem_en",   longint'(bus.mem_en), 0);
    chk("rst_mem_addr", longint'(bus.mem_addr), ROW_BASE);
    chk("rst_count",    longint'(bus.count), 0);
    chk("rst_sum_x",    longint'(bus.sum_x), 0);
    chk("rst_sum_y",    longint'(bus.sum_y), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Empty frame
    run_frame(0, "zero", 0, 0, 0, 0, 0, 0, 0, 1'b1, e0);
    wait_idle("zero");
    chk("zero_mem_en_pulses", longint'(en_cnt), IMG_H);

    // Full frame
    run_frame(1, "ones", 307200, 98150400, 73574400, 0, 639, 0, 479, 1'b1, e0);
    wait_idle("ones");

    // Bottom-right pixel, with start pulses mid-scan and during FLUSH that must be ignored
    run_frame(3, "corner", 1, 639, 479, 639, 639, 479, 479, 1'b1, e0);
    wait_cycle(e0, 100);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cycle(e0, DONE_CYC - 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("corner");
    chk("corner_last_addr", longint'(last_addr), 480);

    // Two pixels, aborted at cycle 5000
    run_frame(2, "abort", 0, 0, 0, 0, 0, 0, 0, 1'b0, e0);
    wait_cycle(e0, 5000);
    chk("abort_pre_count", longint'(bus.count), 1);
    chk("abort_pre_sum_x", longint'(bus.sum_x), 5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy",  longint'(bus.busy), 0);
    chk("abort_count", longint'(bus.count), 0);
    chk("abort_sum_x", longint'(bus.sum_x), 0);
    chk("abort_sum_y", longint'(bus.sum_y), 0);
    repeat (30) @(negedge clk);

    // start with abort in IDLE: frame must not start
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", longint'(bus.busy), 0);

    // Restart after abort completes normally
    run_frame(2, "two_px", 2, 605, 307, 5, 600, 7, 300, 1'b1, e0);
    wait_idle("two_px");

    // Asynchronous reset mid-scan
    run_frame(1, "rst_mid", 0, 0, 0, 0, 0, 0, 0, 1'b0, e0);
    wait_cycle(e0, 3000);
    chk("rst_mid_pre_busy", longint'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy",     longint'(bus.busy), 0);
    chk("rst_mid_mem_en",   longint'(bus.mem_en), 0);
    chk("rst_mid_mem_addr", longint'(bus.mem_addr), ROW_BASE);
    chk("rst_mid_count",    longint'(bus.count), 0);
    chk("rst_mid_sum_x",    longint'(bus.sum_x), 0);
    chk("rst_mid_sum_y",    longint'(bus.sum_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_idle_busy", longint'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
